alu_seq: RTL and testbench

//  Parametrised, registered successor to the 4-bit combinational ALU. Accepts one operation per

---
 rtl/alu_seq.sv | 118 +++++++++++
 tb/tb_alu_seq.sv | 139 +++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered valid/ready ALU with iterative shift-add multiply on opcode 111.
// Define ALU_FLAGS_EN to add the Zero/Neg/Ovf result flags.
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [2:0]       Ctrl,
    input  logic             In_valid,
    output logic             In_ready,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] Output_hi,
    output logic             Cout,
    output logic             Out_valid,
`ifdef ALU_FLAGS_EN
    output logic             Zero,
    output logic             Neg,
    output logic             Ovf,
`endif
    input  logic             Out_ready
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] a_r, res_c;
    logic [2*WIDTH-1:0] prod, prod_n;
    logic [WIDTH:0] sum, dif, part;
    logic [CW-1:0] cnt;
    logic cout_c, accept, last;
    assign In_ready = (state == IDLE) | ((state == DONE) & Out_ready);
    assign Out_valid = state == DONE;
    assign accept = In_valid & In_ready;
    assign last = (state == MUL) && (cnt == CW'(WIDTH - 1));
    assign sum = {1'b0, A} + {1'b0, B} + (WIDTH + 1)'(Cin);
    assign dif = {1'b0, A} - {1'b0, B} - (WIDTH + 1)'(Cin);
    // One multiplier bit per cycle: add A into the high half, then shift the whole product right.
    assign part = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_r} : '0);
    assign prod_n = {part, prod[WIDTH-1:1]};
    always_comb begin
        res_c = '0;
        cout_c = 1'b0;
        case (Ctrl)
            3'b000: {cout_c, res_c} = sum;
            3'b001: {cout_c, res_c} = dif;
            3'b010: res_c = A & B;
            3'b011: res_c = A | B;
            3'b100: res_c = A ^ B;
            3'b101: {cout_c, res_c} = {A, Cin};
            3'b110: {res_c, cout_c} = {Cin, A};
            default: ;
        endcase
    end
`ifdef ALU_FLAGS_EN
    logic ovf_c;
    assign ovf_c = (Ctrl == 3'b000) ? (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]) :
                   (Ctrl == 3'b001) ? (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]) : 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: begin
                if (accept) state_n = (Ctrl == 3'b111) ? MUL : DONE;
                else if (state == DONE && Out_ready) state_n = IDLE;
            end
            MUL: if (last) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0;
            prod <= '0;
            cnt <= '0;
            Output <= '0;
            Output_hi <= '0;
            Cout <= 1'b0;
`ifdef ALU_FLAGS_EN
            Zero <= 1'b0;
            Neg <= 1'b0;
            Ovf <= 1'b0;
`endif
        end else if (accept) begin
            if (Ctrl == 3'b111) begin
                a_r <= A;
                prod <= {{WIDTH{1'b0}}, B};
                cnt <= '0;
            end else begin
                Output <= res_c;
                Output_hi <= '0;
                Cout <= cout_c;
`ifdef ALU_FLAGS_EN
                Zero <= res_c == '0;
                Neg <= res_c[WIDTH-1];
                Ovf <= ovf_c;
`endif
            end
        end else if (state == MUL) begin
            prod <= prod_n;
            cnt <= cnt + 1'b1;
            if (last) begin
                Output <= prod_n[WIDTH-1:0];
                Output_hi <= prod_n[2*WIDTH-1:WIDTH];
                Cout <= |prod_n[2*WIDTH-1:WIDTH];
`ifdef ALU_FLAGS_EN
                Zero <= prod_n == '0;
                Neg <= prod_n[WIDTH-1];
                Ovf <= 1'b0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table plus hold, back-to-back and reset-abort sequences for alu_seq.
module tb_alu_seq;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [3:0] a = '0, b = '0;
    logic cin = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [2:0] ctrl = '0;
    logic in_ready, cout, out_valid;
    logic [3:0] out_lo, out_hi;
    int n_chk = 0, n_fail = 0;
`ifdef ALU_FLAGS_EN
    logic zero, neg, ovf;
`endif
    alu_seq #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .A(a), .B(b), .Cin(cin), .Ctrl(ctrl),
        .In_valid(in_valid), .In_ready(in_ready), .Output(out_lo), .Output_hi(out_hi),
        .Cout(cout), .Out_valid(out_valid),
`ifdef ALU_FLAGS_EN
        .Zero(zero), .Neg(neg), .Ovf(ovf),
`endif
        .Out_ready(out_ready)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [2:0] ctrl;
        logic [3:0] a, b;
        logic cin;
        logic [3:0] lo, hi;
        logic co;
        int lat;
    } vec_t;
    vec_t vec[13];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask
    // Issues one op at a negedge, scrambles the inputs after accept, waits (bounded) for the result.
    task automatic run_op(input string name, input logic [2:0] c, input logic [3:0] x, input logic [3:0] y,
                          input logic ci, input int exp_lat);
        int lat;
        chk({name, " in_ready"}, in_ready, 1);
        ctrl = c; a = x; b = y; cin = ci; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; a = ~x; b = ~y; cin = ~ci;
        lat = 1;
        while (!out_valid && lat < 20) begin
            chk({name, " busy in_ready"}, in_ready, 0);
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, lat, exp_lat);
    endtask
    initial begin
        int seen;
        vec[0]  = '{3'b000, 4'b1010, 4'b0100, 1'b0, 4'b1110, 4'b0000, 1'b0, 1};
        vec[1]  = '{3'b000, 4'b1111, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b1, 1};
        vec[2]  = '{3'b001, 4'b0100, 4'b1010, 1'b0, 4'b1010, 4'b0000, 1'b1, 1};
        vec[3]  = '{3'b001, 4'b1000, 4'b0011, 1'b1, 4'b0100, 4'b0000, 1'b0, 1};
        vec[4]  = '{3'b111, 4'b1010, 4'b0100, 1'b0, 4'b1000, 4'b0010, 1'b1, 5};
        vec[5]  = '{3'b010, 4'b1100, 4'b1010, 1'b1, 4'b1000, 4'b0000, 1'b0, 1};
        vec[6]  = '{3'b011, 4'b1100, 4'b0011, 1'b0, 4'b1111, 4'b0000, 1'b0, 1};
        vec[7]  = '{3'b100, 4'b1010, 4'b0110, 1'b0, 4'b1100, 4'b0000, 1'b0, 1};
        vec[8]  = '{3'b101, 4'b1001, 4'b0000, 1'b1, 4'b0011, 4'b0000, 1'b1, 1};
        vec[9]  = '{3'b110, 4'b0110, 4'b0000, 1'b1, 4'b1011, 4'b0000, 1'b0, 1};
        vec[10] = '{3'b111, 4'b1111, 4'b1111, 1'b1, 4'b0001, 4'b1110, 1'b1, 5};
        vec[11] = '{3'b111, 4'b0011, 4'b0101, 1'b0, 4'b1111, 4'b0000, 1'b0, 5};
        vec[12] = '{3'b111, 4'b0000, 4'b1011, 1'b0, 4'b0000, 4'b0000, 1'b0, 5};
        @(negedge clk);
        chk("reset out_valid", out_valid, 0);
        chk("reset output", out_lo, 0);
        chk("reset output_hi", out_hi, 0);
        chk("reset cout", cout, 0);
        chk("reset in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            string n;
            n = $sformatf("v%0d", i);
            run_op(n, vec[i].ctrl, vec[i].a, vec[i].b, vec[i].cin, vec[i].lat);
            chk({n, " output"}, out_lo, vec[i].lo);
            chk({n, " output_hi"}, out_hi, vec[i].hi);
            chk({n, " cout"}, cout, vec[i].co);
        end
        // Consumer stalls on an XOR result while a new ADD waits at the input.
        @(negedge clk);
        out_ready = 1'b0;
        run_op("hold xor", 3'b100, 4'b1010, 4'b0110, 1'b0, 1);
        ctrl = 3'b000; a = 4'b0011; b = 4'b0001; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("hold out_valid", out_valid, 1);
            chk("hold output", out_lo, 4'b1100);
            chk("hold in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 chk("release in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("reload out_valid", out_valid, 1);
        chk("reload output", out_lo, 4'b0100);
        @(negedge clk);
        chk("drained out_valid", out_valid, 0);
        // Reset two cycles into a multiply aborts it.
        ctrl = 3'b111; a = 4'b1111; b = 4'b1111; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", out_valid, 0);
        chk("abort output", out_lo, 0);
        chk("abort in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen += int'(out_valid);
        end
        chk("no stale result", seen, 0);
        run_op("post reset add", 3'b000, 4'b0010, 4'b0011, 1'b0, 1);
        chk("post reset output", out_lo, 4'b0101);
`ifdef ALU_FLAGS_EN
        run_op("flag add", 3'b000, 4'b0111, 4'b0001, 1'b0, 1);
        chk("flag add output", out_lo, 4'b1000);
        chk("flag add ovf", ovf, 1);
        chk("flag add neg", neg, 1);
        chk("flag add zero", zero, 0);
        run_op("flag xor", 3'b100, 4'b1010, 4'b1010, 1'b0, 1);
        chk("flag xor zero", zero, 1);
        chk("flag xor ovf", ovf, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
